// File: rtl/gs_mem_arbiter.sv
// gs_mem_arbiter: shares one async SRAM between the host loader port and the
// General Sound Z80 bus. Every access is sequenced as setup/strobe/latch/release.
// While a GS access is outstanding, the Z80 is held off through WAIT_n.
// Build option: define ARB_FIXED_PRIO_EN to make GS win every tie.
// When it is undefined, ties alternate round-robin.
module gs_mem_arbiter #(
    parameter int AW      = 21,
    parameter int DW      = 8,
    parameter int ACC_CYC = 2
) (
    input  logic          clk12mhz,
    input  logic          rst,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic [DW-1:0] h_rdata,
    output logic          h_ack,
    input  logic          g_mrd,
    input  logic          g_mwr,
    input  logic [AW-1:0] g_addr,
    input  logic [DW-1:0] g_wdata,
    output logic [DW-1:0] g_rdata,
    output logic          g_wait_n,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dq_o,
    output logic          sram_dq_oe,
    input  logic [DW-1:0] sram_dq_i,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic GNT_HOST = 1'b0;
    localparam logic GNT_GS   = 1'b1;

    localparam logic [3:0] ACC_LAST = 4'(ACC_CYC - 1);

    logic [1:0]    state;
    logic [3:0]    acc_cnt;
    logic          cur_gs;
    logic          cur_we;
    logic          last_grant;
    logic          g_served;
    logic          g_pend;
    logic          grant_gs;
    logic [DW-1:0] wdata_q;

    // GS pending/wait and the arbitration decision made in IDLE
    always_comb begin
        g_pend   = (g_mrd | g_mwr) & ~g_served;
        g_wait_n = ~g_pend;
`ifdef ARB_FIXED_PRIO_EN
        grant_gs = g_pend;
`else
        grant_gs = g_pend & (~h_req | (last_grant == GNT_HOST));
`endif
    end

    // SRAM strobes decoded from the access phase; write data is held through DONE
    always_comb begin
        sram_ce_n  = ~((state == S_SETUP) | (state == S_ACCESS));
        sram_oe_n  = ~((state == S_ACCESS) & ~cur_we);
        sram_we_n  = ~((state == S_ACCESS) & cur_we);
        sram_dq_oe = cur_we & (state != S_IDLE);
        sram_dq_o  = wdata_q;
    end

    // Access sequencer, grant registers, read-data latches and GS served flag
    always_ff @(posedge clk12mhz or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            acc_cnt    <= '0;
            cur_gs     <= 1'b0;
            cur_we     <= 1'b0;
            last_grant <= GNT_HOST;
            g_served   <= 1'b0;
            sram_addr  <= '0;
            wdata_q    <= '0;
            h_rdata    <= '0;
            g_rdata    <= '0;
            h_ack      <= 1'b0;
        end else begin
            h_ack <= 1'b0;
            // served flag follows the Z80 strobe, so a strobe dropped mid-access never leaves it set
            if (!g_mrd && !g_mwr)
                g_served <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (g_pend || h_req) begin
                        cur_gs     <= grant_gs;
                        last_grant <= grant_gs ? GNT_GS : GNT_HOST;
                        cur_we     <= grant_gs ? g_mwr : h_we;
                        sram_addr  <= grant_gs ? g_addr : h_addr;
                        wdata_q    <= grant_gs ? g_wdata : h_wdata;
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    acc_cnt <= ACC_LAST;
                    state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (acc_cnt == 4'd0) begin
                        state <= S_DONE;
                        if (cur_gs) begin
                            if (g_mrd || g_mwr)
                                g_served <= 1'b1;
                            if (!cur_we)
                                g_rdata <= sram_dq_i;
                        end else begin
                            h_ack <= 1'b1;
                            if (!cur_we)
                                h_rdata <= sram_dq_i;
                        end
                    end else begin
                        acc_cnt <= acc_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gs_mem_arbiter.sv
// Testbench for gs_mem_arbiter: directed scenarios followed by randomized
// single accesses. All results are checked against a behavioural SRAM model
// and a reference memory.
module tb_gs_mem_arbiter;

    localparam int AW  = 21;
    localparam int DW  = 8;
    localparam int ACC = 2;
    localparam byte CH_G = 8'h47;
    localparam byte CH_H = 8'h48;

    logic          clk12mhz = 1'b0;
    logic          rst;
    logic          h_req, h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata, h_rdata;
    logic          h_ack;
    logic          g_mrd, g_mwr;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata, g_rdata;
    logic          g_wait_n;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq_o;
    logic          sram_dq_oe;
    logic [DW-1:0] sram_dq_i = '0;
    logic          sram_ce_n, sram_oe_n, sram_we_n;

    gs_mem_arbiter #(.AW(AW), .DW(DW), .ACC_CYC(ACC)) dut (
        .clk12mhz(clk12mhz), .rst(rst),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_rdata(h_rdata), .h_ack(h_ack),
        .g_mrd(g_mrd), .g_mwr(g_mwr), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_rdata(g_rdata), .g_wait_n(g_wait_n),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    always #5 clk12mhz = ~clk12mhz;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Content of never-written SRAM locations
    function automatic logic [7:0] dflt(input logic [20:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5C;
    endfunction

    // Behavioural SRAM and bus monitor
    logic [7:0]  smem    [logic [20:0]];
    logic [7:0]  ref_mem [logic [20:0]];
    int          acc_count = 0;
    int          wr_cyc = 0;
    int          rd_cyc = 0;
    logic [7:0]  seen_wdata = '0;
    logic [20:0] seen_addr = '0;
    logic        prev_ce_n = 1'b1;
    byte         glog[$];

    always @(negedge clk12mhz) begin
        if (!sram_we_n) begin
            wr_cyc++;
            seen_wdata = sram_dq_o;
            seen_addr  = sram_addr;
            smem[sram_addr] = sram_dq_o;
        end
        if (!sram_oe_n) begin
            rd_cyc++;
            seen_addr = sram_addr;
            sram_dq_i = smem.exists(sram_addr) ? smem[sram_addr] : dflt(sram_addr);
        end
        if (prev_ce_n && !sram_ce_n) begin
            acc_count++;
            glog.push_back(sram_addr[20] ? CH_H : CH_G);
        end
        prev_ce_n = sram_ce_n;
    end

    function automatic logic [7:0] exp_rd(input logic [20:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic gap();
        @(negedge clk12mhz); #1;
    endtask

    task automatic host_op(input bit we, input logic [20:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd);
        h_we = we; h_addr = a; h_wdata = d; h_req = 1'b1;
        lat = 0;
        while (lat == 0 || (!h_ack && lat < 60)) begin
            @(negedge clk12mhz); #1;
            lat++;
        end
        if (!h_ack) chk("h_ack_timeout", 32'(h_ack), 32'd1);
        h_req = 1'b0;
        rd = h_rdata;
    endtask

    // kind: 0 read, 1 write, 2 write with both MRD and MWR high
    task automatic gs_op(input int kind, input logic [20:0] a, input logic [7:0] d,
                         input bit drop, output int waits, output logic [7:0] rd);
        g_addr = a; g_wdata = d;
        g_mwr = (kind != 0);
        g_mrd = (kind != 1);
        #1;
        waits = 0;
        while (!g_wait_n && waits < 60) begin
            waits++;
            @(negedge clk12mhz); #1;
        end
        if (!g_wait_n) chk("g_wait_timeout", 32'(g_wait_n), 32'd1);
        rd = g_rdata;
        if (drop) begin g_mrd = 1'b0; g_mwr = 1'b0; end
    endtask

    task automatic solo_host(input bit we, input logic [20:0] a, input logic [7:0] d);
        int wr0 = wr_cyc, rd0 = rd_cyc, a0 = acc_count, lat;
        logic [7:0] rd;
        host_op(we, a, d, lat, rd);
        chk("h_latency", 32'(lat), 32'(ACC + 2));
        chk("h_one_access", 32'(acc_count - a0), 32'd1);
        chk("h_strobe_cycles", 32'(we ? wr_cyc - wr0 : rd_cyc - rd0), 32'(ACC));
        chk("h_wrong_strobe", 32'(we ? rd_cyc - rd0 : wr_cyc - wr0), 32'd0);
        chk("h_sram_addr", 32'(seen_addr), 32'(a));
        if (we) begin
            chk("h_bus_wdata", 32'(seen_wdata), 32'(d));
            ref_mem[a] = d;
        end else begin
            chk("h_rdata", 32'(rd), 32'(exp_rd(a)));
        end
        gap();
    endtask

    task automatic solo_gs(input int kind, input logic [20:0] a, input logic [7:0] d);
        int wr0 = wr_cyc, rd0 = rd_cyc, a0 = acc_count, w;
        logic [7:0] rd;
        gs_op(kind, a, d, 1'b1, w, rd);
        chk("g_wait_clocks", 32'(w), 32'(ACC + 2));
        chk("g_one_access", 32'(acc_count - a0), 32'd1);
        chk("g_strobe_cycles", 32'(kind != 0 ? wr_cyc - wr0 : rd_cyc - rd0), 32'(ACC));
        chk("g_wrong_strobe", 32'(kind != 0 ? rd_cyc - rd0 : wr_cyc - wr0), 32'd0);
        chk("g_sram_addr", 32'(seen_addr), 32'(a));
        if (kind != 0) begin
            chk("g_bus_wdata", 32'(seen_wdata), 32'(d));
            ref_mem[a] = d;
        end else begin
            chk("g_rdata", 32'(rd), 32'(exp_rd(a)));
        end
        gap();
    endtask

    // Host write and GS read raised in the same clock. Winner completes after
    // ACC+2 clocks; loser waits for winner DONE, one IDLE clock, then its own access.
    task automatic tie_op(input int k, output byte first);
        int n0 = glog.size(), hl, gw;
        logic [7:0] r1, r2;
        logic [20:0] ha, ga;
        ha = 21'h100000 + 21'(k);
        ga = 21'h000000 + 21'(k);
        fork
            host_op(1'b1, ha, 8'hC0 + 8'(k), hl, r1);
            gs_op(0, ga, 8'h00, 1'b1, gw, r2);
        join
        ref_mem[ha] = 8'hC0 + 8'(k);
        first = (glog.size() > n0) ? glog[n0] : 8'h00;
        chk("tie_winner_clocks", 32'(first == CH_G ? gw : hl), 32'(ACC + 2));
        chk("tie_loser_clocks", 32'(first == CH_G ? hl : gw), 32'(2 * ACC + 5));
        chk("tie_g_rdata", 32'(r2), 32'(exp_rd(ga)));
        gap();
    endtask

    initial begin
        byte f;
        int  a0, r0, lows, w, lat;
        logic [7:0] rd;

        rst = 1'b1;
        h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
        g_mrd = 0; g_mwr = 0; g_addr = '0; g_wdata = '0;
        repeat (3) @(negedge clk12mhz);
        #1;
        chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_h_ack", 32'(h_ack), 32'd0);
        chk("rst_rdata", 32'({h_rdata, g_rdata}), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_wait_n", 32'(g_wait_n), 32'd1);
        rst = 1'b0;
        gap();

        // Ties from reset: last grant is HOST, so GS wins; host then becomes last
        tie_op(0, f);
        chk("tie1_first", 32'(f), 32'(CH_G));
        tie_op(1, f);
        chk("tie2_first", 32'(f), 32'(CH_G));

        // Host write then read-back
        solo_host(1'b1, 21'h0ABCDE, 8'h5A);
        solo_host(1'b0, 21'h0ABCDE, 8'h00);
        chk("h_readback_5a", 32'(h_rdata), 32'h5A);

        // GS read of preloaded data; MRD held afterwards must not re-access
        smem[21'h004000] = 8'h3C;
        ref_mem[21'h004000] = 8'h3C;
        a0 = acc_count;
        gs_op(0, 21'h004000, 8'h00, 1'b0, w, rd);
        chk("g_read_wait", 32'(w), 32'(ACC + 2));
        chk("g_read_3c", 32'(rd), 32'h3C);
        lows = 0;
        repeat (6) begin
            gap();
            if (!g_wait_n) lows++;
        end
        chk("g_held_no_reaccess", 32'(acc_count - a0), 32'd1);
        chk("g_held_wait_high", 32'(lows), 32'd0);
        g_mrd = 1'b0;
        gap();

        // MRD and MWR together is a write
        solo_gs(2, 21'h004020, 8'h6E);

        // Last grant is now GS: a tie goes to the host under round-robin
        tie_op(2, f);
`ifdef ARB_FIXED_PRIO_EN
        chk("tie3_first", 32'(f), 32'(CH_G));
`else
        chk("tie3_first", 32'(f), 32'(CH_H));
`endif

        // GS strobe dropped mid-access: access completes, next strobe is served fresh
        a0 = acc_count; r0 = rd_cyc;
        g_addr = 21'h004010; g_mrd = 1'b1;
        gap(); gap();
        g_mrd = 1'b0;
        repeat (4) gap();
        chk("g_drop_completed", 32'(rd_cyc - r0), 32'(ACC));
        chk("g_drop_one_access", 32'(acc_count - a0), 32'd1);
        solo_gs(0, 21'h004010, 8'h00);

        // Reset during the ACCESS phase of a host write
        h_we = 1'b1; h_addr = 21'h1AAAAA; h_wdata = 8'h77; h_req = 1'b1;
        gap(); gap();
        chk("mid_write_we_low", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
        chk("rst_mid_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_mid_h_ack", 32'(h_ack), 32'd0);
        h_req = 1'b0;
        @(negedge clk12mhz);
        rst = 1'b0;
        #1;
        gap();
        solo_host(1'b1, 21'h1AAAAA, 8'h99);
        solo_host(1'b0, 21'h1AAAAA, 8'h00);

        // Back-to-back GS writes against a continuously requesting host
        solo_host(1'b1, 21'h1BBBBB, 8'h11);
        a0 = acc_count;
        r0 = glog.size();
        fork
            for (int i = 0; i < 3; i++)
                host_op(1'b1, 21'h100200 + 21'(i), 8'hA0 + 8'(i), lat, rd);
            for (int i = 0; i < 3; i++) begin
                gs_op(1, 21'h000100 + 21'(i), 8'h50 + 8'(i), 1'b1, w, rd);
                gap();
            end
        join
        gap();
        chk("b2b_access_count", 32'(acc_count - a0), 32'd6);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_host_data", 32'(smem[21'h100200 + 21'(i)]), 32'(8'hA0 + 8'(i)));
            chk("b2b_gs_data", 32'(smem[21'h000100 + 21'(i)]), 32'(8'h50 + 8'(i)));
            ref_mem[21'h100200 + 21'(i)] = 8'hA0 + 8'(i);
            ref_mem[21'h000100 + 21'(i)] = 8'h50 + 8'(i);
        end
`ifdef ARB_FIXED_PRIO_EN
        chk("b2b_grants", 32'({glog[r0], glog[r0+1], glog[r0+2]}), 32'({CH_G, CH_G, CH_G}));
`else
        chk("b2b_grants", 32'({glog[r0], glog[r0+1], glog[r0+2]}), 32'({CH_G, CH_H, CH_G}));
`endif

        // Randomized single accesses over a small shared address pool
        for (int n = 0; n < 24; n++) begin
            int unsigned side, we, idx;
            logic [20:0] a;
            logic [7:0]  d;
            side = $urandom_range(0, 1);
            we   = $urandom_range(0, 1);
            idx  = $urandom_range(0, 7);
            d    = 8'($urandom);
            a    = 21'h1F0000 + 21'(idx * 32'h111);
            if (side == 0) solo_host(we[0], a, d);
            else           solo_gs(int'(we), a, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
